// File: rtl/hls_deadlock_persist_monitor.sv
// Deadlock persistence monitor for HLS dataflow regions.
// Watches stream stall and sub-instance deadlock flags, and raises a
// registered deadlock flag once the stall condition has held for THRESH
// consecutive cycles. On that flag it also records which source stalled and
// how long the flag has been up.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no stall seen on the last sample, persistence count at 0
//   PENDING | stall seen, counting consecutive stall samples
//   BLOCKED | stall persisted THRESH samples; block flag asserted
module hls_deadlock_persist_monitor #(
  parameter int N_AXIS = 2,
  parameter int N_INST = 1,
  parameter int THRESH = 1,
  parameter bit STICKY = 1'b0
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [N_AXIS-1:0]                            axis_block_sigs,
  input  logic [N_AXIS-1:0]                            axis_mask,
  input  logic [N_INST-1:0]                            inst_block_sigs,
  input  logic [N_INST-1:0]                            inst_idle_sigs,
  input  logic                                         clear,
  output logic                                         block,
  output logic [(($clog2(N_AXIS+N_INST) < 1) ? 1 : $clog2(N_AXIS+N_INST))-1:0] block_idx,
  output logic [15:0]                                  block_cycles
);

  localparam int IDX_W = ($clog2(N_AXIS+N_INST) < 1) ? 1 : $clog2(N_AXIS+N_INST);
  localparam int CNT_W = ($clog2(THRESH+1) < 1) ? 1 : $clog2(THRESH+1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_BLOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        cycles_q, cycles_d;
  logic               block_q;

  logic               raw;
  logic [IDX_W-1:0]   idx_sel;
  logic               found;

  // Stall condition: any unmasked stream stall or any non-idle instance deadlock.
  assign raw = (|(axis_block_sigs & ~axis_mask)) | (|(inst_block_sigs & ~inst_idle_sigs));

  // Priority pick of the stalling source: lowest stream first, then instances.
  always_comb begin
    idx_sel = '0;
    found   = 1'b0;
    for (int i = 0; i < N_AXIS; i++) begin
      if (!found && axis_block_sigs[i] && !axis_mask[i]) begin
        idx_sel = IDX_W'(i);
        found   = 1'b1;
      end
    end
    for (int j = 0; j < N_INST; j++) begin
      if (!found && inst_block_sigs[j] && !inst_idle_sigs[j]) begin
        idx_sel = IDX_W'(N_AXIS + j);
        found   = 1'b1;
      end
    end
  end

  // Next-state logic for the persistence FSM, capture index and cycle counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    cycles_d = cycles_q;
    if (clear) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      idx_d    = '0;
      cycles_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (raw) begin
            if (THRESH == 1) begin
              state_d  = ST_BLOCKED;
              cnt_d    = '0;
              idx_d    = idx_sel;
              cycles_d = 16'd1;
            end else begin
              state_d = ST_PENDING;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        ST_PENDING: begin
          if (!raw) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(THRESH - 1)) begin
            state_d  = ST_BLOCKED;
            cnt_d    = '0;
            idx_d    = idx_sel;
            cycles_d = 16'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_BLOCKED: begin
          if (!STICKY && !raw) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cycles_q != 16'hFFFF) begin
            // Saturate rather than wrap so long hangs stay visibly long.
            cycles_d = cycles_q + 16'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and output registers; reset wins over clear and all transitions.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      cycles_q <= '0;
      block_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      cycles_q <= cycles_d;
      block_q  <= (state_d == ST_BLOCKED);
    end
  end

  assign block        = block_q;
  assign block_idx    = idx_q;
  assign block_cycles = cycles_q;

endmodule

// File: tb/tb_hls_deadlock_persist_monitor.sv
// Bench for hls_deadlock_persist_monitor: three configurations share one
// stimulus stream and are compared every cycle against a run-length model.
module tb_hls_deadlock_persist_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  axis_block_sigs;
  logic [1:0]  axis_mask;
  logic [0:0]  inst_block_sigs;
  logic [0:0]  inst_idle_sigs;
  logic        clear;

  logic        d_blk [3];
  logic [1:0]  d_idx [3];
  logic [15:0] d_cyc [3];

  int thr [3] = '{1, 4, 2};
  bit stk [3] = '{1'b0, 1'b0, 1'b1};

  int m_run [3];
  bit m_blk [3];
  int m_idx [3];
  int m_cyc [3];

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  hls_deadlock_persist_monitor #(.N_AXIS(2), .N_INST(1), .THRESH(1), .STICKY(1'b0)) dut_a (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs), .axis_mask(axis_mask),
    .inst_block_sigs(inst_block_sigs), .inst_idle_sigs(inst_idle_sigs), .clear(clear),
    .block(d_blk[0]), .block_idx(d_idx[0]), .block_cycles(d_cyc[0]));

  hls_deadlock_persist_monitor #(.N_AXIS(2), .N_INST(1), .THRESH(4), .STICKY(1'b0)) dut_b (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs), .axis_mask(axis_mask),
    .inst_block_sigs(inst_block_sigs), .inst_idle_sigs(inst_idle_sigs), .clear(clear),
    .block(d_blk[1]), .block_idx(d_idx[1]), .block_cycles(d_cyc[1]));

  hls_deadlock_persist_monitor #(.N_AXIS(2), .N_INST(1), .THRESH(2), .STICKY(1'b1)) dut_c (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs), .axis_mask(axis_mask),
    .inst_block_sigs(inst_block_sigs), .inst_idle_sigs(inst_idle_sigs), .clear(clear),
    .block(d_blk[2]), .block_idx(d_idx[2]), .block_cycles(d_cyc[2]));

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
  endtask

  // Reference: count consecutive stall samples; flag once the count reaches THRESH.
  task automatic model_edge();
    int  raw;
    int  src;
    raw = 0;
    src = -1;
    for (int i = 0; i < 2; i++)
      if (axis_block_sigs[i] && !axis_mask[i] && src < 0) src = i;
    if (src < 0 && inst_block_sigs[0] && !inst_idle_sigs[0]) src = 2;
    if (src >= 0) raw = 1;
    for (int k = 0; k < 3; k++) begin
      if (reset || clear) begin
        m_run[k] = 0; m_blk[k] = 0; m_idx[k] = 0; m_cyc[k] = 0;
      end else if (m_blk[k]) begin
        if (!stk[k] && raw == 0) begin
          m_blk[k] = 0;
          m_run[k] = 0;
        end else if (m_cyc[k] < 65535) begin
          m_cyc[k] = m_cyc[k] + 1;
        end
      end else if (raw != 0) begin
        m_run[k] = m_run[k] + 1;
        if (m_run[k] >= thr[k]) begin
          m_blk[k] = 1;
          m_idx[k] = src;
          m_cyc[k] = 1;
          m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("block[%0d]", k), int'(d_blk[k]), int'(m_blk[k]));
      check($sformatf("block_idx[%0d]", k), int'(d_idx[k]), m_idx[k]);
      check($sformatf("block_cycles[%0d]", k), int'(d_cyc[k]), m_cyc[k]);
    end
  endtask

  task automatic step(input logic rst, input logic clr, input logic [1:0] ab,
                      input logic [1:0] am, input logic ib, input logic ii,
                      input bit do_cmp);
    reset           = rst;
    clear           = clr;
    axis_block_sigs = ab;
    axis_mask       = am;
    inst_block_sigs = ib;
    inst_idle_sigs  = ii;
    @(posedge clock);
    model_edge();
    #1;
    if (do_cmp) compare_all();
  endtask

  initial begin
    bit          hot;
    logic [1:0]  ab, am;
    logic        ib, ii, clr, rst;

    for (int k = 0; k < 3; k++) begin
      m_run[k] = 0; m_blk[k] = 0; m_idx[k] = 0; m_cyc[k] = 0;
    end

    // Reset
    for (int n = 0; n < 3; n++) step(1, 0, 2'b00, 2'b00, 0, 0, 1);
    check("reset_block", int'(d_blk[0]), 0);
    check("reset_cycles", int'(d_cyc[2]), 0);

    // Single-cycle stall on THRESH=1
    step(0, 0, 2'b00, 2'b00, 0, 0, 1);
    step(0, 0, 2'b01, 2'b00, 0, 0, 1);
    check("t1_block_up", int'(d_blk[0]), 1);
    check("t1_idx", int'(d_idx[0]), 0);
    check("t1_cycles", int'(d_cyc[0]), 1);
    step(0, 0, 2'b00, 2'b00, 0, 0, 1);
    check("t1_block_down", int'(d_blk[0]), 0);

    // THRESH=4: 3 high, 1 low, 4 high
    step(0, 1, 2'b00, 2'b00, 0, 0, 1);
    for (int n = 0; n < 3; n++) step(0, 0, 2'b10, 2'b00, 0, 0, 1);
    check("t4_first_burst", int'(d_blk[1]), 0);
    step(0, 0, 2'b00, 2'b00, 0, 0, 1);
    for (int n = 0; n < 3; n++) step(0, 0, 2'b10, 2'b00, 0, 0, 1);
    check("t4_third_sample", int'(d_blk[1]), 0);
    step(0, 0, 2'b10, 2'b00, 0, 0, 1);
    check("t4_fourth_sample", int'(d_blk[1]), 1);
    check("t4_idx", int'(d_idx[1]), 1);

    // Sticky, instance-sourced
    step(0, 1, 2'b00, 2'b00, 0, 0, 1);
    step(0, 0, 2'b00, 2'b00, 1, 0, 1);
    step(0, 0, 2'b00, 2'b00, 1, 0, 1);
    for (int n = 0; n < 5; n++) step(0, 0, 2'b00, 2'b00, 0, 0, 1);
    check("sticky_block", int'(d_blk[2]), 1);
    check("sticky_idx", int'(d_idx[2]), 2);
    check("sticky_cycles", int'(d_cyc[2]), 6);
    step(0, 1, 2'b00, 2'b00, 0, 0, 1);
    check("sticky_clear_block", int'(d_blk[2]), 0);
    check("sticky_clear_cycles", int'(d_cyc[2]), 0);

    // Masking
    step(0, 0, 2'b11, 2'b01, 0, 0, 1);
    check("mask_idx", int'(d_idx[0]), 1);
    step(0, 1, 2'b00, 2'b00, 0, 0, 1);
    for (int n = 0; n < 6; n++) step(0, 0, 2'b11, 2'b11, 1, 1, 1);
    check("all_masked_a", int'(d_blk[0]), 0);
    check("all_masked_c", int'(d_blk[2]), 0);

    // Reset mid-BLOCKED, then clear+reset together
    for (int r = 0; r < 2; r++) begin
      step(0, 1, 2'b00, 2'b00, 0, 0, 1);
      for (int n = 0; n < 100; n++) step(0, 0, 2'b01, 2'b00, 0, 0, 1);
      check("hold_100_cycles", int'(d_cyc[0]), 100);
      step(1, logic'(r), 2'b01, 2'b00, 0, 0, 1);
      check("rst_block", int'(d_blk[0]), 0);
      check("rst_idx", int'(d_idx[0]), 0);
      check("rst_cycles", int'(d_cyc[0]), 0);
    end

    // Randomized traffic
    hot = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) hot = ~hot;
      ab  = hot ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 0);
      am  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      ib  = ($urandom_range(0, 3) == 0);
      ii  = ($urandom_range(0, 1) == 0);
      clr = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step(rst, clr, ab, am, ib, ii, 1);
    end

    // Saturation of block_cycles
    step(0, 1, 2'b00, 2'b00, 0, 0, 1);
    for (int n = 0; n < 70000; n++) step(0, 0, 2'b01, 2'b00, 0, 0, (n % 1000 == 0) || (n > 65530));
    check("sat_cycles", int'(d_cyc[0]), 65535);
    check("sat_block", int'(d_blk[0]), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
